gray_conv_arbiter: RTL and testbench

- Shares one W-bit binary-to-Gray conversion stage among NREQ requesters.
- Round-robin arbitration picks one requester per cycle and registers its converted code with the requester ID.
- Output uses a valid/ready handshake.
- Sits between the counter/pointer sources and the consumers of Gray-coded values, such as FIFO pointer synchronisers.

---
 rtl/gray_conv_arbiter.sv | 127 ++++++++++++
 tb/tb_gray_conv_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter that shares one binary-to-Gray converter among NREQ requesters.
// The winner's Gray code and index are held in a single output register with a valid/ready handshake.
module gray_conv_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] bin_in,
   output logic [NREQ-1:0]   gnt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      gray_out,
   output logic [IDW-1:0]    out_id,
   output logic [7:0]        busy_cnt
);

   // Handshake: a word moves to the consumer on any edge where out_valid && out_ready.
   // A new word is captured whenever the slot is empty or is being drained in the same cycle.

   // Requester vectors are padded to a power of two so an IDW-bit index never goes out of range.
   localparam int NP = 1 << IDW;
   localparam int SW = IDW + 1;
   localparam logic [SW-1:0]  NREQ_S = SW'(NREQ);
   localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

   logic [NP-1:0]  req_pad;
   logic [W-1:0]   bin_arr [NP];
   logic [NP-1:0]  gnt_pad;

   logic           out_valid_q, out_valid_d;
   logic [W-1:0]   gray_q, gray_d;
   logic [IDW-1:0] id_q, id_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [7:0]     busy_q, busy_d;

   logic           slot_free;
   logic           accept;
   logic           win_found;
   logic [IDW-1:0] win_idx;
   logic [SW-1:0]  cand;
   logic [W-1:0]   win_bin;

   assign req_pad = NP'(req);

   for (genvar g = 0; g < NP; g++) begin : g_bin
      if (g < NREQ) begin : g_real
         assign bin_arr[g] = bin_in[g*W +: W];
      end else begin : g_pad
         assign bin_arr[g] = '0;
      end
   end

   // Scan starting at rr_ptr with wrap; the first set request wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = {1'b0, rr_ptr_q} + SW'(i);
         if (cand >= NREQ_S) begin
            cand = cand - NREQ_S;
         end
         if (!win_found && req_pad[cand[IDW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IDW-1:0];
         end
      end
   end

   assign slot_free = !out_valid_q || out_ready;
   assign accept    = !rst && slot_free && win_found;
   assign win_bin   = bin_arr[win_idx];

   always_comb begin
      gnt_pad = '0;
      if (accept) begin
         gnt_pad = NP'(1) << win_idx;
      end
   end

   assign gnt = gnt_pad[NREQ-1:0];

   always_comb begin
      out_valid_d = out_valid_q;
      gray_d      = gray_q;
      id_d        = id_q;
      rr_ptr_d    = rr_ptr_q;
      busy_d      = busy_q;
      if (accept) begin
         out_valid_d = 1'b1;
         gray_d      = win_bin ^ (win_bin >> 1);
         id_d        = win_idx;
         rr_ptr_d    = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      // Stall monitor: requests pending but nothing taken this cycle.
      if ((req != '0) && !accept && (busy_q != 8'hFF)) begin
         busy_d = busy_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         gray_q      <= '0;
         id_q        <= '0;
         rr_ptr_q    <= '0;
         busy_q      <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         gray_q      <= gray_d;
         id_q        <= id_d;
         rr_ptr_q    <= rr_ptr_d;
         busy_q      <= busy_d;
      end
   end

   assign out_valid = out_valid_q;
   assign gray_out  = gray_q;
   assign out_id    = id_q;
   assign busy_cnt  = busy_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter: reset, conversion sweep, rotation,
// backpressure, pop-and-accept, mid-run reset and stall-counter saturation.
module tb_gray_conv_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] bin_in;
   logic [3:0]  gnt;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  gray_out;
   logic [1:0]  out_id;
   logic [7:0]  busy_cnt;

   int n_checks;
   int n_fail;

   gray_conv_arbiter #(.NREQ(4), .W(4), .IDW(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .bin_in    (bin_in),
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .gray_out  (gray_out),
      .out_id    (out_id),
      .busy_cnt  (busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   logic [3:0] gray_tbl [16];
   logic [3:0] rr_gray  [4];

   initial begin
      n_checks = 0;
      n_fail   = 0;
      gray_tbl = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                   4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
      rr_gray  = '{4'h2, 4'h7, 4'hC, 4'hB};

      // Reset with all requesters asking
      rst       = 1'b1;
      req       = 4'hF;
      bin_in    = 16'h0;
      out_ready = 1'b1;
      repeat (3) tick();
      check_eq("rst_gnt", 32'(gnt), 32'h0);
      check_eq("rst_valid", 32'(out_valid), 32'h0);
      check_eq("rst_gray", 32'(gray_out), 32'h0);
      check_eq("rst_id", 32'(out_id), 32'h0);
      check_eq("rst_busy", 32'(busy_cnt), 32'h0);
      rst = 1'b0;
      req = 4'h0;
      tick();
      tick();
      check_eq("idle_valid", 32'(out_valid), 32'h0);
      check_eq("idle_gnt", 32'(gnt), 32'h0);
      check_eq("idle_busy", 32'(busy_cnt), 32'h0);

      // Requester 2 sweeps all binary values
      for (int v = 0; v < 16; v++) begin
         req            = 4'b0100;
         bin_in[8 +: 4] = 4'(v);
         settle();
         check_eq("sweep_gnt", 32'(gnt), 32'h4);
         tick();
         check_eq("sweep_valid", 32'(out_valid), 32'h1);
         check_eq("sweep_gray", 32'(gray_out), 32'(gray_tbl[v]));
         check_eq("sweep_id", 32'(out_id), 32'h2);
      end
      req = 4'h0;
      tick();
      check_eq("sweep_drain", 32'(out_valid), 32'h0);

      // Reset again so the pointer restarts at 0, then rotate with all requesting
      rst = 1'b1;
      tick();
      rst    = 1'b0;
      req    = 4'hF;
      bin_in = {4'hD, 4'h8, 4'h5, 4'h3};
      for (int k = 0; k < 8; k++) begin
         settle();
         check_eq("rr_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
         tick();
         check_eq("rr_gray", 32'(gray_out), 32'(rr_gray[k % 4]));
         check_eq("rr_id", 32'(out_id), 32'(k % 4));
      end

      // Backpressure with requesters 0 and 1
      req    = 4'b0011;
      bin_in = {4'h0, 4'h0, 4'hA, 4'h5};
      settle();
      check_eq("bp_first_gnt", 32'(gnt), 32'h1);
      tick();
      check_eq("bp_first_gray", 32'(gray_out), 32'h7);
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         settle();
         check_eq("bp_gnt", 32'(gnt), 32'h0);
         tick();
         check_eq("bp_valid", 32'(out_valid), 32'h1);
         check_eq("bp_gray", 32'(gray_out), 32'h7);
         check_eq("bp_id", 32'(out_id), 32'h0);
      end
      check_eq("bp_busy", 32'(busy_cnt), 32'd5);
      out_ready = 1'b1;
      settle();
      check_eq("bp_resume_gnt", 32'(gnt), 32'h2);
      tick();
      check_eq("bp_resume_gray", 32'(gray_out), 32'hF);
      check_eq("bp_resume_id", 32'(out_id), 32'h1);

      // Pop and accept in the same cycle
      req    = 4'b1000;
      bin_in = {4'h6, 4'h0, 4'h0, 4'h0};
      settle();
      check_eq("pa_gnt", 32'(gnt), 32'h8);
      tick();
      check_eq("pa_valid", 32'(out_valid), 32'h1);
      check_eq("pa_gray", 32'(gray_out), 32'h5);
      check_eq("pa_id", 32'(out_id), 32'h3);
      check_eq("pa_busy", 32'(busy_cnt), 32'd5);

      // Move the pointer to 2, then reset while a word is held and requests are up
      req    = 4'b0010;
      bin_in = {4'h0, 4'h9, 4'hA, 4'h0};
      tick();
      check_eq("mr_pre_id", 32'(out_id), 32'h1);
      req = 4'b0110;
      rst = 1'b1;
      settle();
      check_eq("mr_rst_gnt", 32'(gnt), 32'h0);
      tick();
      check_eq("mr_valid", 32'(out_valid), 32'h0);
      check_eq("mr_gray", 32'(gray_out), 32'h0);
      check_eq("mr_busy", 32'(busy_cnt), 32'h0);
      rst = 1'b0;
      settle();
      check_eq("mr_first_gnt", 32'(gnt), 32'h2);
      tick();
      check_eq("mr_first_gray", 32'(gray_out), 32'hF);
      check_eq("mr_first_id", 32'(out_id), 32'h1);

      // Long stall: the monitor must stop at 255
      out_ready = 1'b0;
      req       = 4'b0001;
      repeat (260) tick();
      check_eq("sat_busy", 32'(busy_cnt), 32'd255);
      check_eq("sat_gray", 32'(gray_out), 32'hF);
      check_eq("sat_gnt", 32'(gnt), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
